// File: rtl/setup_packet_assembler_if.sv
// Receive-side byte stream plus delivery port toward the control endpoint block.
// master drives bytes/busy (upstream + control block side), slave is the assembler.
interface setup_packet_assembler_if;
    logic        setup_tok;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_eop;
    logic        busy;
    logic [63:0] data;
    logic        enable;

    modport master (
        output setup_tok, rx_byte, rx_valid, rx_eop, busy,
        input  data, enable
    );

    modport slave (
        input  setup_tok, rx_byte, rx_valid, rx_eop, busy,
        output data, enable
    );
endinterface

// File: rtl/setup_packet_assembler.sv
// Checks a post-SETUP DATA0 packet (PID, length, CRC16) and packs the 8 setup bytes into one word.
// Word strobes 2 clks after eop when busy is low; while busy it waits in a one-deep holding register.
module setup_packet_assembler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    setup_packet_assembler_if.slave   bus,
    output logic [CNT_W-1:0]          crc_err_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int              IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [7:0]      PID_DATA0 = 8'hC3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DATA,
        S_CHECK,
        S_REJECT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [IDLE_W-1:0]  r_idle;
    logic [15:0]        r_crc;
    logic [7:0]         r_pkt [0:9];
    logic [63:0]        r_hold;
    logic               r_pending;
    logic [63:0]        r_data;
    logic               r_enable;
    logic [CNT_W-1:0]   r_crc_err;
    logic [CNT_W-1:0]   r_drop;

    logic               w_accept_pid;
    logic               w_store;
    logic               w_timeout;
    logic               w_latch;
    logic               w_idle_run;
    logic               w_crc_ok;
    logic [15:0]        w_crc_nxt;
    logic [63:0]        w_word;
    logic               w_drop_inc;

    // Reflected CRC16 (0xA001), data bits consumed LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign w_crc_nxt = crc16_upd(r_crc, bus.rx_byte);
    assign w_crc_ok  = (~r_crc == {r_pkt[9], r_pkt[8]});
    assign w_word    = {r_pkt[0], r_pkt[1], r_pkt[3], r_pkt[2],
                        r_pkt[5], r_pkt[4], r_pkt[7], r_pkt[6]};

    always_comb begin
        w_state_nxt  = r_state;
        w_accept_pid = 1'b0;
        w_store      = 1'b0;
        w_timeout    = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.setup_tok) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (bus.setup_tok) begin
                    w_state_nxt = S_ARMED;
                end else if (bus.rx_valid) begin
                    if (bus.rx_byte == PID_DATA0 && !bus.rx_eop) begin
                        w_state_nxt  = S_DATA;
                        w_accept_pid = 1'b1;
                    end else begin
                        w_state_nxt = S_REJECT;
                    end
                end else if (r_idle == IDLE_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.setup_tok) begin
                    w_state_nxt = S_ARMED;
                end else if (bus.rx_valid) begin
                    if (r_cnt == 4'd10) begin
                        w_state_nxt = S_REJECT;
                    end else begin
                        w_store = 1'b1;
                        if (bus.rx_eop) w_state_nxt = (r_cnt == 4'd9) ? S_CHECK : S_REJECT;
                    end
                end else if (bus.rx_eop) begin
                    w_state_nxt = (r_cnt == 4'd10) ? S_CHECK : S_REJECT;
                end else if (r_idle == IDLE_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_CHECK: begin
                w_latch = w_crc_ok;
                if (!w_crc_ok)          w_state_nxt = S_REJECT;
                else if (bus.setup_tok) w_state_nxt = S_ARMED;
                else                    w_state_nxt = S_IDLE;
            end
            S_REJECT: begin
                w_state_nxt = bus.setup_tok ? S_ARMED : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The gap counter only advances while waiting inside a packet; any byte or restart clears it.
    assign w_idle_run = (r_state == S_ARMED || r_state == S_DATA) && (w_state_nxt == r_state)
                        && !bus.rx_valid && !bus.setup_tok;
    assign w_drop_inc = w_timeout || (w_latch && r_pending && bus.busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idle    <= '0;
            r_crc     <= 16'hFFFF;
            r_hold    <= 64'd0;
            r_pending <= 1'b0;
            r_data    <= 64'd0;
            r_enable  <= 1'b0;
            r_crc_err <= '0;
            r_drop    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idle   <= w_idle_run ? r_idle + 1'b1 : '0;
            r_enable <= 1'b0;

            if (w_accept_pid) begin
                r_cnt <= 4'd0;
                r_crc <= 16'hFFFF;
            end else if (w_store) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt < 4'd8) r_crc <= w_crc_nxt;
            end

            // A fresh word with nothing pending goes straight out; otherwise the older word wins the slot.
            if (w_latch) begin
                r_hold <= w_word;
                if (r_pending) begin
                    if (!bus.busy) begin
                        r_data   <= r_hold;
                        r_enable <= 1'b1;
                    end
                end else if (!bus.busy) begin
                    r_data   <= w_word;
                    r_enable <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end else if (r_pending && !bus.busy) begin
                r_data    <= r_hold;
                r_enable  <= 1'b1;
                r_pending <= 1'b0;
            end

            if (r_state == S_REJECT && r_crc_err != '1) r_crc_err <= r_crc_err + 1'b1;
            if (w_drop_inc && r_drop != '1)             r_drop    <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_pkt[r_cnt] <= bus.rx_byte;
    end

    assign bus.data    = r_data;
    assign bus.enable  = r_enable;
    assign crc_err_cnt = r_crc_err;
    assign drop_cnt    = r_drop;

endmodule

// File: doc/setup_packet_assembler.md
Name: setup_packet_assembler

Overview:
- Upstream feeder for the control endpoint block.
- Takes the byte stream of a DATA0 packet that follows a SETUP token and checks its PID, length and CRC16.
- Packs the 8 setup bytes into the 64-bit word layout used by the control block: bmRequestType, bRequest, wValue, wIndex, wLength.
- Presents the word with a one-cycle enable, respecting the control block's busy flag.

Parameters:
- TIMEOUT, 64, max clk cycles between consecutive rx_valid bytes inside a packet before the packet is aborted.
- CNT_W, 8, width of the error/drop counters (saturating).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- setup_tok  input  1  one-cycle pulse: SETUP token addressed to this endpoint was received
- rx_byte  input  8  received byte (PID, data and CRC bytes, in wire order)
- rx_valid  input  1  rx_byte valid this cycle
- rx_eop  input  1  end of packet; may coincide with the last rx_valid
- busy  input  1  control block busy; a word is not delivered while high
- data  output  64  {bmRequestType[63:56], bRequest[55:48], wValue[47:32], wIndex[31:16], wLength[15:0]}
- enable  output  1  one-cycle strobe; data is valid in that cycle
- crc_err_cnt  output  CNT_W  count of packets rejected for bad CRC, PID or length
- drop_cnt  output  CNT_W  count of pending words overwritten before delivery, plus timeouts

Behaviour:
- Reset values: data=0, enable=0, both counters=0, state=IDLE, pending flag=0.
- Byte/field mapping (USB little-endian):
  - b0 -> [63:56]
  - b1 -> [55:48]
  - wValue = {b3,b2}
  - wIndex = {b5,b4}
  - wLength = {b7,b6}
- CRC16:
  - Polynomial 0x8005, processed LSB-first per byte (reflected form 0xA001), init 0xFFFF, result complemented.
  - Received CRC is b8 (low byte) then b9; it must equal the computed value.
  - Computed serially, one byte per rx_valid; no extra latency.
- State machine:
  - IDLE: setup_tok -> ARMED.
  - ARMED: first rx_valid byte is the PID.
    - 0xC3 (DATA0) -> DATA, byte counter cleared.
    - Any other PID -> REJECT.
    - Timeout -> IDLE with drop_cnt+1.
  - DATA: each rx_valid stores the byte at the counter index and increments the counter (0..9).
    - rx_eop with exactly 10 bytes received -> CHECK.
    - rx_eop with fewer bytes, or an 11th byte -> REJECT.
  - CHECK (one cycle):
    - CRC OK -> latch the assembled word into the holding register, set pending -> IDLE.
    - CRC bad -> REJECT.
  - REJECT (one cycle): crc_err_cnt+1, discard bytes -> IDLE. Any pending word is untouched.
- Timeout:
  - Idle counter runs in ARMED and DATA, cleared on every rx_valid.
  - Reaching TIMEOUT -> IDLE, drop_cnt+1, partial packet discarded.
- Delivery:
  - When pending=1 and busy=0, the next cycle drives data = holding register and enable=1 for exactly one cycle, then clears pending.
  - data holds its value after enable drops until the next delivery.
- Latency: rx_eop on the 10th byte at cycle N gives CHECK at N+1 and enable at N+2 if busy=0.
- Overwrite: a new valid packet completing CHECK while pending=1 replaces the holding register (newest setup wins, per USB) and increments drop_cnt.
- Simultaneous events:
  - setup_tok arriving in ARMED or DATA restarts at ARMED; the partial packet is silently dropped, no counter change.
  - CHECK latching in the same cycle as delivery: delivery uses the old word; the new word becomes pending.
- busy high indefinitely: pending is held; no enable is issued.
- Counters saturate at all-ones.
- Reset mid-packet: immediate return to the reset values above; no enable.

Test Plan:
- setup_tok, then C3 80 06 00 01 00 00 40 00 DD 94 with eop on 0x94, busy=0 -> enable one cycle 2 clks after eop, data=64'h8006_0100_0000_0040.
- Same bytes with the last byte 0x95 -> no enable, crc_err_cnt=1, data unchanged.
- Packet with PID 0x4B, or eop after 9 bytes -> REJECT, crc_err_cnt increments, no enable.
- busy=1 during a valid packet and held 20 clks -> enable stays 0; enable pulses once on the cycle after busy falls. A second valid packet while pending -> drop_cnt=1 and the second word is delivered.
- setup_tok then PID and 3 bytes, then silence for TIMEOUT clks -> state back to IDLE, drop_cnt=1; a following full valid packet is delivered normally.
- rst asserted at the 5th data byte -> enable=0, counters=0, data=0; a subsequent valid packet is delivered correctly.
